// File: rtl/write_module_pkg.sv
// Shared definitions for the write_module_continue slice.
//
// Contents:
//   op_type_e            - operation selector (OP_SCALAR = 0, OP_VECTOR = 1)
//   ADDR_WIDTH_DEFAULT   - default address width in bits
//   VEC_OFFSET_DEFAULT   - default distance from base to final vector element
//   DONE_COUNT_WIDTH     - width of the completed-operation counter
package write_module_pkg;

    typedef enum logic {
        OP_SCALAR = 1'b0,
        OP_VECTOR = 1'b1
    } op_type_e;

    localparam int unsigned ADDR_WIDTH_DEFAULT = 10;
    localparam int unsigned VEC_OFFSET_DEFAULT = 20;
    localparam int unsigned DONE_COUNT_WIDTH   = 16;

endpackage

// File: rtl/wmc_last_addr.sv
// Final-address generator for vector writes.
//
// Computes the last element address of a vector write as
// (base_address + VEC_OFFSET) mod 2^ADDR_WIDTH. When WMC_RANGE_CHECK_EN is
// defined it also reports whether write_address lies inside the modular
// window base_address..last_address (inclusive), which may wrap past the top
// of the address space.
//
// Ports:
//   base_address   in   ADDR_WIDTH  start address of the current operation
//   write_address  in   ADDR_WIDTH  address currently being written
//   last_address   out  ADDR_WIDTH  final element address (wrapping)
//   in_range       out  1           write_address within the window
//                                   (only with WMC_RANGE_CHECK_EN)
module wmc_last_addr
    import write_module_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int unsigned VEC_OFFSET = VEC_OFFSET_DEFAULT
) (
    input  logic [ADDR_WIDTH-1:0] base_address,
`ifdef WMC_RANGE_CHECK_EN
    input  logic [ADDR_WIDTH-1:0] write_address,
    output logic [ADDR_WIDTH-1:0] last_address,
    output logic                  in_range
`else
    output logic [ADDR_WIDTH-1:0] last_address
`endif
);

    // Offset truncated to the address width so the sum wraps naturally.
    localparam logic [ADDR_WIDTH-1:0] OFFSET = ADDR_WIDTH'(VEC_OFFSET);

    assign last_address = base_address + OFFSET;

`ifdef WMC_RANGE_CHECK_EN
    logic [ADDR_WIDTH-1:0] rel_address;

    // Distance from base in modular arithmetic; the window is inclusive and
    // spans exactly OFFSET addresses past base, so a single compare suffices
    // even when the window wraps past the top of the address space.
    assign rel_address = write_address - base_address;
    assign in_range    = (rel_address <= OFFSET);
`endif

endmodule

// File: rtl/write_module_continue.sv
// Write-completion tracker.
//
// Flags completion of a scalar or vector write. A scalar write completes when
// the written address equals the base address; a vector write completes on
// its final element at base + VEC_OFFSET (wrapping). The completion flag is
// purely combinational; a registered copy qualified by write_valid and a
// wrapping 16-bit count of completed operations are also provided. No other
// operation state is held, so op_type/base_address changes act immediately.
//
// Optional feature (macro WMC_RANGE_CHECK_EN): a registered addr_error flag
// that marks valid vector writes outside the modular base..last window.
//
// Ports:
//   clk            in   1           clock, rising edge
//   rst_n          in   1           synchronous active-low reset
//   base_address   in   ADDR_WIDTH  start address of the current operation
//   write_address  in   ADDR_WIDTH  address currently being written
//   op_type        in   1           0 scalar, 1 vector
//   write_valid    in   1           qualifies write_address for registered logic
//   write_done     out  1           combinational completion flag
//   write_done_q   out  1           registered, write_valid-qualified completion
//   done_count     out  16          completed operation count (wraps)
//   addr_error     out  1           out-of-range vector write (macro only)
module write_module_continue
    import write_module_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int unsigned VEC_OFFSET = VEC_OFFSET_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_WIDTH-1:0]       base_address,
    input  logic [ADDR_WIDTH-1:0]       write_address,
    input  logic                        op_type,
    input  logic                        write_valid,
    output logic                        write_done,
    output logic                        write_done_q,
`ifdef WMC_RANGE_CHECK_EN
    output logic [DONE_COUNT_WIDTH-1:0] done_count,
    output logic                        addr_error
`else
    output logic [DONE_COUNT_WIDTH-1:0] done_count
`endif
);

    op_type_e                    op;
    logic [ADDR_WIDTH-1:0]       last_address;
    logic                        done_valid;
    logic                        write_done_d;
    logic [DONE_COUNT_WIDTH-1:0] done_count_q;
    logic [DONE_COUNT_WIDTH-1:0] done_count_d;
    logic                        write_done_r;

    assign op = op_type_e'(op_type);

`ifdef WMC_RANGE_CHECK_EN
    logic in_range;
    logic addr_error_q;
    logic addr_error_d;

    wmc_last_addr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .VEC_OFFSET (VEC_OFFSET)
    ) u_last_addr (
        .base_address  (base_address),
        .write_address (write_address),
        .last_address  (last_address),
        .in_range      (in_range)
    );
`else
    wmc_last_addr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .VEC_OFFSET (VEC_OFFSET)
    ) u_last_addr (
        .base_address (base_address),
        .last_address (last_address)
    );
`endif

    // Completion flag: independent of clock, reset and write_valid.
    always_comb begin
        write_done = 1'b0;
        unique case (op)
            OP_SCALAR: write_done = (write_address == base_address);
            OP_VECTOR: write_done = (write_address == last_address);
            default:   write_done = 1'b0;
        endcase
    end

    assign done_valid = write_valid & write_done;

    always_comb begin
        write_done_d = done_valid;
        done_count_d = done_count_q;
        if (done_valid) begin
            done_count_d = done_count_q + DONE_COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_done_r <= 1'b0;
            done_count_q <= '0;
        end else begin
            write_done_r <= write_done_d;
            done_count_q <= done_count_d;
        end
    end

    assign write_done_q = write_done_r;
    assign done_count   = done_count_q;

`ifdef WMC_RANGE_CHECK_EN
    // Only valid vector writes are range checked; scalar writes never flag.
    always_comb begin
        addr_error_d = write_valid & (op == OP_VECTOR) & ~in_range;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_error_q <= 1'b0;
        end else begin
            addr_error_q <= addr_error_d;
        end
    end

    assign addr_error = addr_error_q;
`endif

endmodule

// File: tb/tb_write_module_continue.sv
module tb_write_module_continue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  base_address;
    logic [9:0]  write_address;
    logic        op_type;
    logic        write_valid;
    logic        write_done;
    logic        write_done_q;
    logic [15:0] done_count;
`ifdef WMC_RANGE_CHECK_EN
    logic        addr_error;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    write_module_continue #(
        .ADDR_WIDTH (10),
        .VEC_OFFSET (20)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .base_address  (base_address),
        .write_address (write_address),
        .op_type       (op_type),
        .write_valid   (write_valid),
        .write_done    (write_done),
        .write_done_q  (write_done_q),
`ifdef WMC_RANGE_CHECK_EN
        .done_count    (done_count),
        .addr_error    (addr_error)
`else
        .done_count    (done_count)
`endif
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] base, input logic [9:0] wr, input logic op,
                         input logic vld);
        base_address  = base;
        write_address = wr;
        op_type       = op;
        write_valid   = vld;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(10'd0, 10'd0, 1'b0, 1'b0);
        tick();
        tick();
        check("reset_done_q", {15'd0, write_done_q}, 16'd0);
        check("reset_count", done_count, 16'd0);
        check("reset_comb_scalar", {15'd0, write_done}, 16'd1);
        rst_n = 1'b1;

        // Scalar
        drive(10'd573, 10'd573, 1'b0, 1'b0);
        check("scalar_hit", {15'd0, write_done}, 16'd1);
        drive(10'd573, 10'd574, 1'b0, 1'b0);
        check("scalar_miss", {15'd0, write_done}, 16'd0);
        drive(10'd573, 10'd593, 1'b0, 1'b0);
        check("scalar_at_last", {15'd0, write_done}, 16'd0);

        // Vector
        drive(10'd573, 10'd573, 1'b1, 1'b0);
        check("vec_base", {15'd0, write_done}, 16'd0);
        drive(10'd573, 10'd582, 1'b1, 1'b0);
        check("vec_582", {15'd0, write_done}, 16'd0);
        drive(10'd573, 10'd592, 1'b1, 1'b0);
        check("vec_592", {15'd0, write_done}, 16'd0);
        drive(10'd573, 10'd593, 1'b1, 1'b0);
        check("vec_last", {15'd0, write_done}, 16'd1);

        // Wrap past top of address space: 1015 + 20 = 1035 -> 11
        drive(10'd1015, 10'd11, 1'b1, 1'b0);
        check("wrap_hit", {15'd0, write_done}, 16'd1);
        drive(10'd1015, 10'd10, 1'b1, 1'b0);
        check("wrap_10", {15'd0, write_done}, 16'd0);
        drive(10'd1015, 10'd1015, 1'b1, 1'b0);
        check("wrap_base", {15'd0, write_done}, 16'd0);

        // Registered path
        drive(10'd573, 10'd593, 1'b1, 1'b1);
        tick();
        check("reg_q_set", {15'd0, write_done_q}, 16'd1);
        check("reg_count1", done_count, 16'd1);
        drive(10'd573, 10'd593, 1'b1, 1'b0);
        check("novalid_comb", {15'd0, write_done}, 16'd1);
        tick();
        check("novalid_q", {15'd0, write_done_q}, 16'd0);
        check("novalid_count", done_count, 16'd1);
        drive(10'd573, 10'd592, 1'b1, 1'b1);
        tick();
        check("valid_miss_q", {15'd0, write_done_q}, 16'd0);
        check("valid_miss_count", done_count, 16'd1);
        drive(10'd573, 10'd573, 1'b0, 1'b1);
        tick();
        check("scalar_reg_q", {15'd0, write_done_q}, 16'd1);
        check("scalar_reg_count", done_count, 16'd2);
        drive(10'd573, 10'd593, 1'b1, 1'b1);
        tick();
        check("count3", done_count, 16'd3);

        // Reset does not gate the combinational flag
        rst_n = 1'b0;
        tick();
        check("rst_count", done_count, 16'd0);
        check("rst_q", {15'd0, write_done_q}, 16'd0);
        check("rst_comb_hit", {15'd0, write_done}, 16'd1);
        drive(10'd573, 10'd573, 1'b1, 1'b1);
        check("rst_comb_miss", {15'd0, write_done}, 16'd0);
        tick();
        check("rst_hold_count", done_count, 16'd0);
        rst_n = 1'b1;

`ifdef WMC_RANGE_CHECK_EN
        drive(10'd573, 10'd600, 1'b1, 1'b1);
        tick();
        check("rng_out", {15'd0, addr_error}, 16'd1);
        drive(10'd573, 10'd580, 1'b1, 1'b1);
        tick();
        check("rng_in", {15'd0, addr_error}, 16'd0);
        drive(10'd1015, 10'd5, 1'b1, 1'b1);
        tick();
        check("rng_wrap_in", {15'd0, addr_error}, 16'd0);
        drive(10'd1015, 10'd12, 1'b1, 1'b1);
        tick();
        check("rng_wrap_out", {15'd0, addr_error}, 16'd1);
        drive(10'd573, 10'd600, 1'b0, 1'b1);
        tick();
        check("rng_scalar", {15'd0, addr_error}, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_module_continue.md
WRITE_MODULE_CONTINUE -- requirements
Module: write_module_continue

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set the address width in bits.
REQ-002 Parameter VEC_OFFSET, default 20, SHALL set the distance from base address to the final element address of a vector write.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, synchronous and active-low.
REQ-005 base_address  input  ADDR_WIDTH  SHALL carry the start address of the current write operation.
REQ-006 write_address  input  ADDR_WIDTH  SHALL carry the address currently being written.
REQ-007 op_type  input  1  SHALL select the operation: 0 scalar, 1 vector.
REQ-008 write_valid  input  1  SHALL qualify write_address for the registered tracking logic only.
REQ-009 write_done  output  1  SHALL be the combinational completion flag.
REQ-010 write_done_q  output  1  SHALL be write_done registered and qualified by write_valid.
REQ-011 done_count  output  16  SHALL count completed operations.
REQ-012 addr_error  output  1  SHALL flag an out-of-range vector address; present only when WMC_RANGE_CHECK_EN is defined.

Function
REQ-013 last_address SHALL equal (base_address + VEC_OFFSET) modulo 2^ADDR_WIDTH, so the target wraps past the top of the address space.
REQ-014 Scalar (op_type=0): write_done SHALL be 1 iff write_address == base_address.
REQ-015 Vector (op_type=1): write_done SHALL be 1 iff write_address == last_address, and 0 for every other address, including base_address.
REQ-016 write_done SHALL be purely combinational, with zero-cycle latency from any input change, and SHALL be independent of clk, rst_n and write_valid.
REQ-017 On each rising clk edge with rst_n=1, write_done_q SHALL load (write_valid AND write_done).
REQ-018 On each rising clk edge with rst_n=1, done_count SHALL increment by 1 when write_valid AND write_done; it SHALL wrap from 0xFFFF to 0x0000.
REQ-019 A change of op_type or base_address mid-operation SHALL take effect immediately; no operation state is held beyond write_done_q and done_count.

Reset
REQ-020 While rst_n=0 at a rising edge, write_done_q SHALL become 0 and done_count SHALL become 0; under the macro, any registered error state SHALL also become 0.
REQ-021 Reset SHALL NOT gate the combinational write_done.

Configuration
REQ-022 With macro WMC_RANGE_CHECK_EN defined, addr_error SHALL be registered and SHALL load (write_valid AND op_type AND write_address is not within the modular range base_address..last_address inclusive) each rising clk edge; reset SHALL clear it.
REQ-023 Without WMC_RANGE_CHECK_EN, the addr_error port and its logic SHALL be absent.

Structure
REQ-024 A shared package write_module_pkg SHALL hold the op-type enum (OP_SCALAR=0, OP_VECTOR=1) and the ADDR_WIDTH and VEC_OFFSET default constants.
REQ-025 One sub-module, wmc_last_addr, SHALL compute last_address and the modular in-range comparison; all other logic SHALL stay in the top module.

Verification
REQ-026 Scalar case: base=573, write=573, op=0 -> write_done=1.
REQ-027 Vector start: base=573, write=573, op=1 -> write_done=0; write=582 -> 0; write=592 -> 0; write=593 -> 1.
REQ-028 Wrap case: base=1015, op=1, write=11 -> write_done=1; write=10 -> 0.
REQ-029 Registered path: base=573, op=1, write=593 with write_valid=1 for one cycle -> write_done_q=1 the next cycle, then 0; done_count goes 0 -> 1. The same stimulus with write_valid=0 -> write_done=1, but write_done_q and done_count are unchanged.
REQ-030 Reset: assert rst_n=0 for one edge after done_count=3 -> done_count=0 and write_done_q=0, while write_done still follows the inputs combinationally.
REQ-031 With WMC_RANGE_CHECK_EN: base=573, op=1, write_valid=1, write=600 -> addr_error=1 next cycle; write=580 -> addr_error=0.
